riscv_run_monitor: RTL
======================

// Module: riscv_run_monitor
// PURPOSE
//   Synthesisable run controller/checker for the pipelined RISC-V core. Sequences core
//   reset, runs the program, detects halt (PC self-loop), bounds runtime with a watchdog,
//   then compares NUM_ELEM result words against expected values and reports pass/fail.
//   Sits beside RISC_V_Processor on the board/bench top; generalises fixed 8-element check.
// PARAMETERS
//   DATA_W         64   width of each result element and of pc_in
//   NUM_ELEM       8    number of result elements checked (>=1)
//   RESET_CYCLES   2    cycles core_reset is held after start (>=1)
//   STABLE_CYCLES  4    consecutive unchanged-PC cycles that mean "halted" (>=1)
//   TIMEOUT_CYCLES 700  max RUN cycles before watchdog fires (>=2)
//   CNT_W          32   width of cycle_count
// PORTS
//   clk           in   1                 clock, rising edge
//   reset         in   1                 async, active-low; 0 = reset
//   start         in   1                 1-cycle pulse: begin a run (IDLE/DONE only)
//   pc_in         in   DATA_W            core fetch PC, sampled every RUN cycle
//   elem_flat     in   NUM_ELEM*DATA_W   core results; element i = [i*DATA_W +: DATA_W]
//   exp_flat      in   NUM_ELEM*DATA_W   expected values, same packing
//   core_reset    out  1                 active-high reset to core
//   busy          out  1                 1 in RESET_HOLD/RUN/CHECK
//   done          out  1                 1 in DONE
//   pass          out  1                 valid when done; 1 = all elements matched
//   timeout       out  1                 valid when done; 1 = watchdog fired
//   mismatch_idx  out  max(1,$clog2(NUM_ELEM))  index of first mismatching element
//   cycle_count   out  CNT_W             RUN cycles elapsed; saturates at all-ones
// BEHAVIOUR
//   Reset (reset=0, any time incl. mid-run): state=IDLE, core_reset=1, busy=done=pass=
//     timeout=0, mismatch_idx=0, cycle_count=0, internal counters/prev-PC cleared.
//   States: IDLE -> RESET_HOLD -> RUN -> CHECK -> DONE; DONE -> RESET_HOLD on start.
//   IDLE: core_reset=1. start=1 -> RESET_HOLD next cycle.
//   RESET_HOLD: core_reset=1 exactly RESET_CYCLES cycles; entry clears pass/timeout/
//     mismatch_idx/cycle_count; then RUN.
//   RUN: core_reset=0; cycle_count+1 per cycle (saturating). prev_pc registered each
//     cycle; stable counter +1 when pc_in==prev_pc, else cleared to 0. First RUN cycle
//     never counts as stable (prev_pc invalid).
//     stable reaches STABLE_CYCLES -> CHECK next cycle.
//     cycle_count reaches TIMEOUT_CYCLES-1 with no halt -> DONE, timeout=1, pass=0.
//     Halt and timeout in same cycle: halt wins (go CHECK, timeout=0).
//   CHECK: one element per cycle, idx 0..NUM_ELEM-1, registered compare of full DATA_W.
//     First mismatch at idx k -> DONE, pass=0, mismatch_idx=k (rest skipped).
//     All match -> DONE after NUM_ELEM cycles, pass=1, mismatch_idx=0.
//     elem_flat/exp_flat must be stable during CHECK (core is halted).
//   DONE: core_reset=0 (core state left inspectable); outputs held until start/reset.
//   start ignored in RESET_HOLD/RUN/CHECK. cycle_count frozen outside RUN.
//   Latency: start -> core_reset falls after RESET_CYCLES+1 cycles; halt -> done in
//     <= NUM_ELEM+1 cycles.
// TESTING
//   T1 defaults; pc loops at 0x40 from RUN cycle 20; elem=exp={1..8} -> done, pass=1,
//      timeout=0, cycle_count=25 (20+4 stable+1).
//   T2 same but elem[5]=0xDEAD, exp[5]=6 -> done, pass=0, mismatch_idx=5.
//   T3 pc increments by 4 forever -> done at cycle_count=699, timeout=1, pass=0.
//   T4 halt reached exactly on cycle 699 -> CHECK taken, timeout=0.
//   T5 reset=0 for 1 cycle mid-RUN (cycle 300) -> IDLE, core_reset=1, all outputs 0;
//      new start runs cleanly from cycle_count=0.
//   T6 NUM_ELEM=3, DATA_W=32, RESET_CYCLES=5: core_reset high 5 cycles; start pulses
//      during RUN ignored; restart from DONE clears pass/timeout.

Source files
------------

// File: rtl/riscv_run_monitor_if.sv
// Bus bundle between the RISC-V run monitor and its driver: run control,
// core observation inputs and the pass/fail report.
interface riscv_run_monitor_if #(
    parameter int DATA_W   = 64,
    parameter int NUM_ELEM = 8,
    parameter int CNT_W    = 32
);
    localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

    logic                         start;
    logic [DATA_W-1:0]            pc_in;
    logic [NUM_ELEM*DATA_W-1:0]   elem_flat;
    logic [NUM_ELEM*DATA_W-1:0]   exp_flat;
    logic                         core_reset;
    logic                         busy;
    logic                         done;
    logic                         pass;
    logic                         timeout;
    logic [IDX_W-1:0]             mismatch_idx;
    logic [CNT_W-1:0]             cycle_count;

    modport master (
        output start, pc_in, elem_flat, exp_flat,
        input  core_reset, busy, done, pass, timeout, mismatch_idx, cycle_count
    );

    modport slave (
        input  start, pc_in, elem_flat, exp_flat,
        output core_reset, busy, done, pass, timeout, mismatch_idx, cycle_count
    );
endinterface

// File: rtl/riscv_run_monitor.sv
// Run controller/checker for the pipelined RISC-V core: holds core reset, runs until
// the PC self-loops or the watchdog fires, then compares result words one per cycle.
module riscv_run_monitor #(
    parameter int DATA_W         = 64,
    parameter int NUM_ELEM       = 8,
    parameter int RESET_CYCLES   = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 700,
    parameter int CNT_W          = 32
) (
    input logic               clk,
    input logic               reset,
    riscv_run_monitor_if.slave bus
);
    localparam int IDX_W  = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HOLD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_ELEM - 1);

    logic [2:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [STAB_W-1:0] stable_cnt;
    logic [DATA_W-1:0] prev_pc;
    logic              prev_valid;
    logic [IDX_W-1:0]  chk_idx;
    logic              pass_r;
    logic              timeout_r;
    logic [IDX_W-1:0]  mis_idx_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [CNT_W-1:0]  cnt_inc;
    logic              pc_same;
    logic              halt;
    logic [DATA_W-1:0] cur_elem;
    logic [DATA_W-1:0] cur_exp;

    always_comb begin
        cnt_inc  = (&cnt_r) ? cnt_r : cnt_r + 1'b1;
        pc_same  = prev_valid && (bus.pc_in == prev_pc);
        // halt is the cycle on which the stable run reaches STABLE_CYCLES
        halt     = pc_same && (stable_cnt == STAB_LAST);
        cur_elem = bus.elem_flat[chk_idx*DATA_W +: DATA_W];
        cur_exp  = bus.exp_flat[chk_idx*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            stable_cnt <= '0;
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            chk_idx    <= '0;
            pass_r     <= 1'b0;
            timeout_r  <= 1'b0;
            mis_idx_r  <= '0;
            cnt_r      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state      <= S_HOLD;
                        hold_cnt   <= '0;
                        stable_cnt <= '0;
                        prev_valid <= 1'b0;
                        pass_r     <= 1'b0;
                        timeout_r  <= 1'b0;
                        mis_idx_r  <= '0;
                        cnt_r      <= '0;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= S_RUN;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    cnt_r      <= cnt_inc;
                    prev_pc    <= bus.pc_in;
                    prev_valid <= 1'b1;
                    stable_cnt <= pc_same ? stable_cnt + 1'b1 : '0;
                    if (halt) begin
                        state   <= S_CHECK;
                        chk_idx <= '0;
                    end else if (cnt_inc == CNT_LAST) begin
                        state     <= S_DONE;
                        timeout_r <= 1'b1;
                        pass_r    <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (cur_elem != cur_exp) begin
                        state     <= S_DONE;
                        pass_r    <= 1'b0;
                        mis_idx_r <= chk_idx;
                    end else if (chk_idx == IDX_LAST) begin
                        state  <= S_DONE;
                        pass_r <= 1'b1;
                    end else begin
                        chk_idx <= chk_idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.core_reset   = (state == S_IDLE) || (state == S_HOLD);
    assign bus.busy         = (state == S_HOLD) || (state == S_RUN) || (state == S_CHECK);
    assign bus.done         = (state == S_DONE);
    assign bus.pass         = pass_r;
    assign bus.timeout      = timeout_r;
    assign bus.mismatch_idx = mis_idx_r;
    assign bus.cycle_count  = cnt_r;
endmodule
